// File: rtl/sha256_block_feeder.sv
// SHA-256 message block feeder: packs message words into a 16-word block buffer,
// appends 0x80 padding and the 64-bit bit length, and hands each block to the hash core.
module sha256_block_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] msg_word,
    input  logic        msg_valid,
    input  logic        msg_last,
    input  logic [2:0]  msg_nbytes,
    output logic        msg_ready,
    input  logic [3:0]  block_offset,
    output logic [31:0] w,
    output logic        update,
    input  logic        core_done,
    output logic        digest_valid,
    output logic        busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 5;
    localparam int unsigned LEN_W  = 64;

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD_ZERO,
        S_LEN_HI,
        S_LEN_LO,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    wptr;
    logic [LEN_W-1:0]    length;
    logic                pad_pending;
    logic                final_blk;
    logic                msg_done;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic [2:0]          nb_c;
    logic [WORD_W-1:0]   last_word_c;
    logic [LEN_W-1:0]    add_c;
    logic                accept_c;

    // Byte count of the final word, saturated at 4, and the word with its 0x80 marker merged in.
    always_comb begin
        nb_c = (msg_nbytes > 3'd4) ? 3'd4 : msg_nbytes;
        case (nb_c)
            3'd0:    last_word_c = 32'h8000_0000;
            3'd1:    last_word_c = {msg_word[31:24], 24'h80_0000};
            3'd2:    last_word_c = {msg_word[31:16], 16'h8000};
            3'd3:    last_word_c = {msg_word[31:8], 8'h80};
            default: last_word_c = msg_word;
        endcase
        add_c    = msg_last ? LEN_W'({nb_c, 3'b000}) : LEN_W'(32);
        accept_c = msg_valid & msg_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_FILL;
            wptr         <= '0;
            length       <= '0;
            pad_pending  <= 1'b0;
            final_blk    <= 1'b0;
            msg_done     <= 1'b0;
            update       <= 1'b0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            msg_ready    <= 1'b0;
            w            <= '0;
        end else begin
            update       <= 1'b0;
            digest_valid <= 1'b0;
            msg_ready    <= 1'b0;
            w            <= mem[block_offset];
            case (state)
                S_FILL: begin
                    msg_ready <= 1'b1;
                    if (accept_c) begin
                        busy                <= 1'b1;
                        wptr                <= wptr + PTR_W'(1);
                        length              <= length + add_c;
                        mem[wptr[3:0]]      <= msg_last ? last_word_c : msg_word;
                        if (msg_last) begin
                            msg_done    <= 1'b1;
                            pad_pending <= (nb_c == 3'd4);
                            msg_ready   <= 1'b0;
                            state       <= (wptr == PTR_W'(15)) ? S_ISSUE : S_PAD_ZERO;
                        end else if (wptr == PTR_W'(15)) begin
                            msg_ready <= 1'b0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_PAD_ZERO: begin
                    if (wptr == PTR_W'(14) && !pad_pending) begin
                        state <= S_LEN_HI;
                    end else if (wptr == PTR_W'(16)) begin
                        state <= S_ISSUE;
                    end else begin
                        mem[wptr[3:0]] <= pad_pending ? 32'h8000_0000 : 32'h0;
                        pad_pending    <= 1'b0;
                        wptr           <= wptr + PTR_W'(1);
                        if (wptr == PTR_W'(15)) begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_LEN_HI: begin
                    mem[14] <= length[63:32];
                    wptr    <= PTR_W'(15);
                    state   <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    mem[15]   <= length[31:0];
                    wptr      <= PTR_W'(16);
                    final_blk <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    update <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        wptr <= '0;
                        if (final_blk) begin
                            digest_valid <= 1'b1;
                            length       <= '0;
                            busy         <= 1'b0;
                            final_blk    <= 1'b0;
                            msg_done     <= 1'b0;
                            msg_ready    <= 1'b1;
                            state        <= S_FILL;
                        end else if (msg_done) begin
                            // Padding or length words still owed after a full data block.
                            state <= S_PAD_ZERO;
                        end else begin
                            msg_ready <= 1'b1;
                            state     <= S_FILL;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: byte-level SHA-256 padding model compared against
// every word of every block the feeder presents to a simple core responder.
module tb_sha256_block_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] msg_word;
    logic        msg_valid;
    logic        msg_last;
    logic [2:0]  msg_nbytes;
    logic        msg_ready;
    logic [3:0]  block_offset;
    logic [31:0] w;
    logic        update;
    logic        core_done;
    logic        digest_valid;
    logic        busy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_q[$];

    sha256_block_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .msg_word     (msg_word),
        .msg_valid    (msg_valid),
        .msg_last     (msg_last),
        .msg_nbytes   (msg_nbytes),
        .msg_ready    (msg_ready),
        .block_offset (block_offset),
        .w            (w),
        .update       (update),
        .core_done    (core_done),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Standard SHA-256 padding of a byte string, regrouped into big-endian words.
    task automatic build_expected(input byte unsigned m[$]);
        logic [63:0]  bits;
        byte unsigned p[$];
        bits = 64'(m.size()) * 64'd8;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int i = 0; i < p.size(); i += 4)
            exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    endtask

    task automatic drive_word(input logic [31:0] wd, input logic last, input logic [2:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        msg_valid  = 1'b1;
        msg_word   = wd;
        msg_last   = last;
        msg_nbytes = nb;
        while (msg_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check("accept_timeout", 64'(msg_ready), 64'(1));
        @(posedge clk);
        #1;
        msg_valid  = 1'b0;
        msg_word   = $urandom;
        msg_last   = 1'($urandom);
        msg_nbytes = 3'($urandom);
    endtask

    task automatic send_msg(input byte unsigned m[$], input bit xz);
        int nw;
        bit extra;
        nw    = (m.size() + 3) / 4;
        extra = xz && (m.size() > 0) && (m.size() % 4 == 0);
        if (nw == 0) begin
            drive_word($urandom, 1'b1, 3'd0);
        end else begin
            for (int k = 0; k < nw; k++) begin
                logic [31:0] wd;
                logic [2:0]  nb;
                int          rem;
                rem = m.size() - 4 * k;
                for (int j = 0; j < 4; j++)
                    wd[31-8*j -: 8] = (4*k + j < m.size()) ? m[4*k + j] : 8'($urandom);
                nb = (rem >= 4) ? 3'($urandom_range(4, 7)) : 3'(rem);
                drive_word(wd, (k == nw - 1) && !extra, nb);
            end
            if (extra) drive_word($urandom, 1'b1, 3'd0);
        end
    endtask

    task automatic wait_update(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (update !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(update), 64'(1));
    endtask

    // Core responder: read each block back through block_offset, then pulse core_done.
    task automatic service(input int nblk);
        bit fin;
        for (int b = 0; b < nblk; b++) begin
            wait_update($sformatf("update_b%0d", b));
            check("ready_low_in_wait", 64'(msg_ready), 64'(0));
            check("busy_in_wait", 64'(busy), 64'(1));
            block_offset = 4'd0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (i == 0) check("update_one_cycle", 64'(update), 64'(0));
                check($sformatf("w_b%0d_%0d", b, i), 64'(w), 64'(exp_q[b*16 + i]));
                block_offset = 4'(i + 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fin = (b == nblk - 1);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            check($sformatf("digest_b%0d", b), 64'(digest_valid), 64'(fin));
            check($sformatf("busy_after_b%0d", b), 64'(busy), 64'(!fin));
            if (fin) begin
                @(negedge clk);
                check("digest_one_cycle", 64'(digest_valid), 64'(0));
            end
        end
    endtask

    task automatic run_msg(input byte unsigned m[$], input bit xz);
        int extra_upd;
        build_expected(m);
        fork
            send_msg(m, xz);
            service(exp_q.size() / 16);
        join
        extra_upd = 0;
        repeat (20) begin
            @(negedge clk);
            if (update === 1'b1) extra_upd++;
        end
        check("no_extra_update", 64'(extra_upd), 64'(0));
        check("ready_idle", 64'(msg_ready), 64'(1));
    endtask

    initial begin
        byte unsigned m[$];
        reset        = 1'b0;
        msg_valid    = 1'b0;
        msg_word     = '0;
        msg_last     = 1'b0;
        msg_nbytes   = '0;
        block_offset = '0;
        core_done    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(msg_ready), 64'(0));
        check("rst_update", 64'(update), 64'(0));
        check("rst_digest", 64'(digest_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_w", 64'(w), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(msg_ready), 64'(1));

        // "abc"
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);

        // Empty message
        m.delete();
        run_msg(m, 1'b0);

        // 14 full words, then 16 full words
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);
        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);

        // Reset pulse while the core holds a block, then a stray core_done
        m = '{8'h61, 8'h62, 8'h63};
        build_expected(m);
        fork
            send_msg(m, 1'b0);
            wait_update("update_before_rst");
        join
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_digest", 64'(digest_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ready", 64'(msg_ready), 64'(0));
        check("midrst_w", 64'(w), 64'(0));
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("stray_done_digest", 64'(digest_valid), 64'(0));
        check("stray_done_ready", 64'(msg_ready), 64'(1));
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);

        // Random lengths, sometimes closing with an extra nbytes=0 word
        for (int r = 0; r < 8; r++) begin
            m.delete();
            for (int i = 0; i < int'($urandom_range(0, 140)); i++) m.push_back(8'($urandom));
            run_msg(m, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
